// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between a requester and seq_divider.
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results of the last operation held
// RUN   | one restoring iteration per edge, WIDTH iterations total
// FIX   | apply signs (or divide-by-zero result), pulse done
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic          clk,
   input logic          rst_n,
   seq_divider_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   // upper half = partial remainder, lower half = dividend shifting into quotient
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     dsr_q, dsr_d;
   logic                 qsign_q, qsign_d;
   logic                 rsign_q, rsign_d;
   logic                 dbz_q, dbz_d;
   logic                 ovf_q, ovf_d;
   logic [WIDTH-1:0]     quot_q, quot_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic                 done_q, done_d;

   logic                 dvd_neg, dsr_neg, dsr_zero, is_ovf;
   logic [WIDTH-1:0]     dvd_mag, dsr_mag;
   logic [WIDTH:0]       up_sh;
   logic                 borrow;
   logic [WIDTH-1:0]     diff;

   assign dvd_neg  = bus.is_signed & bus.dividend[WIDTH-1];
   assign dsr_neg  = bus.is_signed & bus.divisor[WIDTH-1];
   assign dvd_mag  = dvd_neg ? -bus.dividend : bus.dividend;
   assign dsr_mag  = dsr_neg ? -bus.divisor : bus.divisor;
   assign dsr_zero = (bus.divisor == '0);
   assign is_ovf   = bus.is_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.divisor);

   // Partial remainder shifted left by one; it is always below 2*|divisor|,
   // so when the trial subtraction does not borrow the difference fits in WIDTH bits.
   assign up_sh  = acc_q[2*WIDTH-1:WIDTH-1];
   assign borrow = (up_sh < {1'b0, dsr_q});
   assign diff   = up_sh[WIDTH-1:0] - dsr_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dsr_d   = dsr_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               dsr_d   = dsr_mag;
               qsign_d = dvd_neg ^ dsr_neg;
               rsign_d = dvd_neg;
               dbz_d   = dsr_zero;
               ovf_d   = is_ovf;
               // on divide-by-zero the raw dividend is kept so it can be returned as remainder
               acc_d   = {{WIDTH{1'b0}}, (dsr_zero ? bus.dividend : dvd_mag)};
               cnt_d   = '0;
               state_d = dsr_zero ? FIX : RUN;
            end
         end
         RUN: begin
            if (borrow) acc_d = {up_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else        acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            if (dbz_q) begin
               quot_d = '1;
               rem_d  = acc_q[WIDTH-1:0];
            end else begin
               quot_d = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               rem_d  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         dsr_q   <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dsr_q   <= dsr_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_seq_divider;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   t0 = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb32[$];
   exp_t sb8[$];

   seq_divider_if #(.WIDTH(32)) if32 ();
   seq_divider_if #(.WIDTH(8))  if8 ();

   seq_divider #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
   seq_divider #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Scoreboard monitors: compare every presented result against the queue head
   always @(negedge clk) begin
      if (rst_n && if32.done) begin
         if (sb32.size() == 0) begin
            chk("mon32_unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb32.pop_front();
            chk("mon32_quotient", if32.quotient, e.q);
            chk("mon32_remainder", if32.remainder, e.r);
            chk("mon32_div_by_zero", if32.div_by_zero, e.dbz);
            chk("mon32_overflow", if32.overflow, e.ovf);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && if8.done) begin
         if (sb8.size() == 0) begin
            chk("mon8_unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb8.pop_front();
            chk("mon8_quotient", {24'h0, if8.quotient}, e.q);
            chk("mon8_remainder", {24'h0, if8.remainder}, e.r);
            chk("mon8_div_by_zero", if8.div_by_zero, e.dbz);
            chk("mon8_overflow", if8.overflow, e.ovf);
         end
      end
   end

   task automatic launch(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input bit dbz, input bit ovf,
                         input bit push);
      exp_t e;
      e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
      @(negedge clk);
      if (w8) begin
         if8.start = 1'b1; if8.is_signed = sgn; if8.dividend = a[7:0]; if8.divisor = b[7:0];
         if (push) sb8.push_back(e);
      end else begin
         if32.start = 1'b1; if32.is_signed = sgn; if32.dividend = a; if32.divisor = b;
         if (push) sb32.push_back(e);
      end
      @(posedge clk);
      #1;
      t0 = cyc;
      if32.start = 1'b0;
      if8.start  = 1'b0;
      chk(w8 ? "busy8_after_accept" : "busy32_after_accept", w8 ? if8.busy : if32.busy, 1);
   endtask

   task automatic wait_done(input bit w8, input int exp_lat);
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (w8 ? if8.done : if32.done) seen = 1'b1;
      end
      if (!seen) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("latency", cyc - t0, exp_lat);
         chk("busy_low_at_done", w8 ? if8.busy : if32.busy, 0);
         @(posedge clk);
         #1;
         chk("done_one_cycle", w8 ? if8.done : if32.done, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      if32.start = 0; if32.is_signed = 0; if32.dividend = '0; if32.divisor = '0;
      if8.start  = 0; if8.is_signed  = 0; if8.dividend  = '0; if8.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", if32.busy, 0);
      chk("rst_done", if32.done, 0);
      chk("rst_quotient", if32.quotient, 0);
      chk("rst_remainder", if32.remainder, 0);
      chk("rst_flags", {if32.div_by_zero, if32.overflow}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // unsigned / signed basics at WIDTH=32
      launch(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 1);                    wait_done(0, 33);
      launch(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 1); wait_done(0, 33);
      launch(0, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 0, 1);        wait_done(0, 33);
      launch(0, 0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 0, 0, 1);        wait_done(0, 33);

      // divide by zero, then flag clears on next op
      launch(0, 0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, 0, 1);          wait_done(0, 1);
      launch(0, 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0, 1);                        wait_done(0, 33);
      launch(0, 1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1, 0, 1); wait_done(0, 1);

      // signed overflow
      launch(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 1, 1); wait_done(0, 33);

      // start while busy is ignored
      launch(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      if32.start = 1'b1; if32.is_signed = 1'b1; if32.dividend = 32'd5; if32.divisor = 32'd5;
      @(posedge clk);
      #1;
      if32.start = 1'b0;
      wait_done(0, 33);

      // reset mid-operation: outputs clear at once and no done follows
      launch(0, 0, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 0, 0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", if32.busy, 0);
      chk("midrst_done", if32.done, 0);
      chk("midrst_quotient", if32.quotient, 0);
      chk("midrst_remainder", if32.remainder, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         bit saw = 1'b0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (if32.done || if32.busy) saw = 1'b1;
         end
         chk("midrst_no_activity", saw, 0);
      end
      launch(0, 0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 0, 1);                      wait_done(0, 33);

      // WIDTH=8 instance
      launch(1, 0, 32'd200, 32'd3, 32'd66, 32'd2, 0, 0, 1);                     wait_done(1, 9);
      launch(1, 1, 32'h80, 32'hFF, 32'h80, 32'h00, 0, 1, 1);                    wait_done(1, 9);
      launch(1, 1, 32'hF9, 32'h02, 32'hFD, 32'hFF, 0, 0, 1);                    wait_done(1, 9);
      launch(1, 0, 32'hAB, 32'h00, 32'hFF, 32'hAB, 1, 0, 1);                    wait_done(1, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb32_drained", sb32.size(), 0);
      chk("sb8_drained", sb8.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
